run_seq_detect: RTL and testbench
=================================

RUN_SEQ_DETECT -- requirements
Module: run_seq_detect

Interface
REQ-001 The block SHALL have parameter SYM_W, default 2, meaning symbol width in bits.
REQ-002 The block SHALL have parameter N_STAGES, default 3, meaning number of ascending stages, with the legal range 2..2^SYM_W-1.
REQ-003 The block SHALL have parameter MID_RUN, default 1, meaning the minimum run length for stages 1..N_STAGES-1, with MID_RUN >= 1.
REQ-004 The block SHALL have parameter LAST_RUN, default 2, meaning the minimum run length for stage N_STAGES, with LAST_RUN >= 1.
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning the match counter width.
REQ-006 Port clk SHALL be an input of width 1: the single clock, rising edge.
REQ-007 Port reset SHALL be an input of width 1: synchronous, active-high reset.
REQ-008 Port en SHALL be an input of width 1: sample enable.
REQ-009 Port num SHALL be an input of width SYM_W: the input symbol.
REQ-010 Port clr_cnt SHALL be an input of width 1: synchronous clear of match_cnt.
REQ-011 Port ans SHALL be an output of width 1: a level, high while the full pattern is satisfied.
REQ-012 Port hit SHALL be an output of width 1: a one-cycle pulse per new match.
REQ-013 Port match_cnt SHALL be an output of width CNT_W: a saturating count of matches.
REQ-014 Port stage SHALL be an output of width SYM_W: the current stage, where 0 means idle.

Function
REQ-015 The block SHALL act only on the rising edge of clk; all outputs SHALL be registered; there SHALL be no combinational input-to-output path.
REQ-016 The block SHALL hold stage s (0..N_STAGES) and run counter r; r SHALL saturate at max(MID_RUN, LAST_RUN).
REQ-017 When en=1, the block SHALL apply the following rules to num in priority order.
 - num==1: if s==1, r increments; otherwise s=1 and r=1.
 - num==s with s>=2: r increments.
 - num==s+1 with 1<=s<N_STAGES and r>=MID_RUN: s=s+1 and r=1.
 - Any other value (0, > N_STAGES, backward step, skipped stage, advance on a short run, or num==s+1 when s==N_STAGES): s=0 and r=0.
REQ-018 When en=0, the block SHALL hold s, r, ans and match_cnt, and SHALL force hit=0.
REQ-019 ans SHALL be 1 in the cycle after an edge that leaves s==N_STAGES with r>=LAST_RUN; otherwise ans SHALL be 0.
REQ-020 hit SHALL be 1 for exactly one cycle after the edge at which r reaches LAST_RUN in stage N_STAGES, i.e. when ans rises; further symbols that extend that run SHALL NOT re-pulse hit.
REQ-021 Latency SHALL be one cycle: ans and hit SHALL be visible after the edge that samples the LAST_RUN-th final-stage symbol.
REQ-022 match_cnt SHALL increment by 1 on each hit and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 clr_cnt=1 SHALL set match_cnt to 0; if hit occurs at the same edge, match_cnt SHALL become 1.
REQ-024 A stage-1 symbol arriving while s>1 SHALL restart the pattern, so the pattern may overlap with a following sequence.
REQ-025 The stage output SHALL equal s.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL set s=0, r=0, ans=0, hit=0 and match_cnt=0, with priority over en and clr_cnt.
REQ-027 A reset asserted mid-pattern SHALL discard all progress, and a full pattern SHALL be required after reset is released.

Structure
REQ-028 The shared header SHALL define the default SYM_W, N_STAGES, MID_RUN, LAST_RUN and CNT_W values and the named constant STAGE_IDLE=0.
REQ-029 The block SHALL contain one sub-module, sat_counter, a parametrised width/max saturating counter with inc and clr inputs, used for both r and match_cnt.
REQ-030 The stage transition logic SHALL be a single combinational next-state block feeding one registered state block.

Verification
REQ-031 A bench SHALL use defaults and 10 ns clk, and SHALL check that reset=1 for 2 cycles with num=1 held -> stage=0, ans=0, hit=0, match_cnt=0.
REQ-032 A bench SHALL check that num = 0,1,1,2,3,3,1,2,1,1,1,2,2,3,3,3,1 (en=1) -> hit pulses after the 6th and 15th symbols; ans is high after symbols 6, 15 and 16 only; final match_cnt=2.
REQ-033 A bench SHALL check that num = 1,3,3 -> stage returns to 0 on the 3 (skipped stage); ans stays 0.
REQ-034 A bench SHALL check that num = 1,2,3 with en=0 during the 2 then 3,3 -> stage holds at 1 while en=0; no hit until the pattern completes with en=1.
REQ-035 A bench SHALL check that, with CNT_W=2, 5 complete patterns -> match_cnt=3, saturated; clr_cnt asserted together with the 6th hit -> match_cnt=1.
REQ-036 A bench SHALL check that reset pulsed after 1,2,3 (one short of LAST_RUN) followed by a single 3 -> no hit; stage=0 after the reset, then stage=0 after the 3.

Source files
------------

// File: rtl/run_seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module : run_seq_detect_pkg
// Brief  : Shared defaults, stage constants and rule-action encoding for
//          the ascending run-sequence detector.
// Rev    : 1.0  initial release
// ============================================================================
package run_seq_detect_pkg;

    localparam int DEF_SYM_W    = 2;
    localparam int DEF_N_STAGES = 3;
    localparam int DEF_MID_RUN  = 1;
    localparam int DEF_LAST_RUN = 2;
    localparam int DEF_CNT_W    = 8;

    localparam int STAGE_IDLE   = 0;

    // One action per sampled symbol, chosen by the rule priority chain.
    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_RESTART = 3'd1,
        ACT_EXTEND  = 3'd2,
        ACT_ADVANCE = 3'd3,
        ACT_ABORT   = 3'd4
    } act_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Width/max parametrised saturating up-counter; clr and inc on the
//          same edge yields 1.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_count_next;

    always_comb begin
        w_base       = clr ? '0 : count;
        w_count_next = w_base;
        if (inc && (w_base != MAX)) begin
            w_count_next = w_base + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/run_seq_detect.sv
`default_nettype none
// ============================================================================
// Module : run_seq_detect
// Brief  : Detects ascending symbol runs 1..N_STAGES with minimum run lengths
//          and counts completed matches.
// Rev    : 1.0  initial release
// ============================================================================
module run_seq_detect
    import run_seq_detect_pkg::*;
#(
    parameter int SYM_W    = DEF_SYM_W,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int MID_RUN  = DEF_MID_RUN,
    parameter int LAST_RUN = DEF_LAST_RUN,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SYM_W-1:0] num,
    input  logic             clr_cnt,
    output logic             ans,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SYM_W-1:0] stage
);

    localparam int RUN_MAX = max_int(MID_RUN, LAST_RUN);
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [SYM_W-1:0] STG_IDLE  = SYM_W'(STAGE_IDLE);
    localparam logic [SYM_W-1:0] STG_FIRST = SYM_W'(1);
    localparam logic [SYM_W-1:0] STG_TWO   = SYM_W'(2);
    localparam logic [SYM_W-1:0] STG_LAST  = SYM_W'(N_STAGES);

    localparam logic [RUN_W-1:0] RUN_SAT     = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] RUN_MID     = RUN_W'(MID_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST_M1 = RUN_W'(LAST_RUN - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
    localparam bit               LAST_IS_ONE = (LAST_RUN == 1);

    act_e             w_act;
    logic [SYM_W-1:0] r_stage;
    logic [SYM_W-1:0] w_stage_next;
    logic [SYM_W:0]   w_num_x;
    logic [SYM_W:0]   w_succ_x;
    logic             w_run_inc;
    logic             w_run_clr;
    logic [RUN_W-1:0] w_run;
    logic             r_ans;
    logic             w_ans_next;
    logic             r_hit;
    logic             w_hit_next;
    logic             w_cnt_clr;

    always_comb begin
        w_num_x      = {1'b0, num};
        w_succ_x     = {1'b0, r_stage} + (SYM_W + 1)'(1);
        w_act        = ACT_ABORT;
        w_stage_next = r_stage;
        w_run_inc    = 1'b0;
        w_run_clr    = 1'b0;
        w_ans_next   = r_ans;
        w_hit_next   = 1'b0;

        if (!en) begin
            w_act = ACT_HOLD;
        end else if (num == STG_FIRST) begin
            w_act = (r_stage == STG_FIRST) ? ACT_EXTEND : ACT_RESTART;
        end else if ((num == r_stage) && (r_stage >= STG_TWO)) begin
            w_act = ACT_EXTEND;
        end else if ((w_num_x == w_succ_x) && (r_stage != STG_IDLE) &&
                     (r_stage < STG_LAST) && (w_run >= RUN_MID)) begin
            w_act = ACT_ADVANCE;
        end

        case (w_act)
            ACT_HOLD: begin
                w_stage_next = r_stage;
            end
            ACT_RESTART: begin
                w_stage_next = STG_FIRST;
                w_run_clr    = 1'b1;
                w_run_inc    = 1'b1;
            end
            ACT_EXTEND: begin
                w_run_inc    = 1'b1;
            end
            ACT_ADVANCE: begin
                w_stage_next = r_stage + SYM_W'(1);
                w_run_clr    = 1'b1;
                w_run_inc    = 1'b1;
            end
            default: begin
                w_stage_next = STG_IDLE;
                w_run_clr    = 1'b1;
            end
        endcase

        // Run after this edge is r+1 (saturated at >= LAST_RUN) on extend,
        // else 1, so the threshold is decided from the current run value.
        if (w_act != ACT_HOLD) begin
            w_ans_next = (w_stage_next == STG_LAST) &&
                         ((w_act == ACT_EXTEND) ? (w_run >= RUN_LAST_M1) : LAST_IS_ONE);
            w_hit_next = w_ans_next && !r_ans;
        end
    end

    assign w_cnt_clr = clr_cnt && en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= STG_IDLE;
            r_ans   <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_stage <= w_stage_next;
            r_ans   <= w_ans_next;
            r_hit   <= w_hit_next;
        end
    end

    sat_counter #(
        .WIDTH (RUN_W),
        .MAX   (RUN_SAT)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_run_clr),
        .inc   (w_run_inc),
        .count (w_run)
    );

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (CNT_SAT)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_hit_next),
        .count (match_cnt)
    );

    assign stage = r_stage;
    assign ans   = r_ans;
    assign hit   = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_run_seq_detect.sv
`default_nettype none
// ============================================================================
// Module : tb_run_seq_detect
// Brief  : Directed scoreboard bench for run_seq_detect (default and CNT_W=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_run_seq_detect;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] num;
    logic       clr_cnt;
    logic       ans,  hit;
    logic       ans2, hit2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [1:0] stage, stage2;

    always #5 clk = ~clk;

    run_seq_detect dut (
        .clk(clk), .reset(reset), .en(en), .num(num), .clr_cnt(clr_cnt),
        .ans(ans), .hit(hit), .match_cnt(match_cnt), .stage(stage)
    );

    run_seq_detect #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .num(num), .clr_cnt(clr_cnt),
        .ans(ans2), .hit(hit2), .match_cnt(match_cnt2), .stage(stage2)
    );

    typedef struct {
        int    stage;
        logic  ans;
        logic  hit;
        int    cnt;
        int    cnt2;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    int   ms, mr, mcnt, mcnt2;
    logic mans, mhit;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s.%s: observed=%0d expected=%0d", tag, field, obs, expv);
    endtask

    // Reference behaviour for the default parameter set (N=3, MID=1, LAST=2).
    task automatic model(input logic rst_i, input logic en_i, input int n, input logic clr_i);
        logic na;
        if (rst_i) begin
            ms = 0; mr = 0; mans = 1'b0; mhit = 1'b0; mcnt = 0; mcnt2 = 0;
        end else if (!en_i) begin
            mhit = 1'b0;
        end else begin
            if (n == 1) begin
                if (ms == 1) mr = (mr < 2) ? mr + 1 : 2;
                else begin ms = 1; mr = 1; end
            end else if (n == ms && ms >= 2) begin
                mr = (mr < 2) ? mr + 1 : 2;
            end else if (n == ms + 1 && ms >= 1 && ms < 3 && mr >= 1) begin
                ms = ms + 1; mr = 1;
            end else begin
                ms = 0; mr = 0;
            end
            na   = (ms == 3) && (mr >= 2);
            mhit = na && !mans;
            mans = na;
            if (clr_i) begin
                mcnt  = mhit ? 1 : 0;
                mcnt2 = mcnt;
            end else if (mhit) begin
                mcnt  = (mcnt  < 255) ? mcnt  + 1 : 255;
                mcnt2 = (mcnt2 < 3)   ? mcnt2 + 1 : 3;
            end
        end
    endtask

    task automatic step(input logic rst_i, input logic en_i, input int n,
                        input logic clr_i, input string tag);
        exp_t e;
        exp_t got;
        reset   = rst_i;
        en      = en_i;
        num     = 2'(n);
        clr_cnt = clr_i;
        model(rst_i, en_i, n, clr_i);
        e.stage = ms; e.ans = mans; e.hit = mhit; e.cnt = mcnt; e.cnt2 = mcnt2; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk(got.tag, "stage",  32'(stage),      32'(got.stage));
        chk(got.tag, "ans",    32'(ans),        32'(got.ans));
        chk(got.tag, "hit",    32'(hit),        32'(got.hit));
        chk(got.tag, "cnt",    32'(match_cnt),  32'(got.cnt));
        chk(got.tag, "stage2", 32'(stage2),     32'(got.stage));
        chk(got.tag, "ans2",   32'(ans2),       32'(got.ans));
        chk(got.tag, "hit2",   32'(hit2),       32'(got.hit));
        chk(got.tag, "cnt2",   32'(match_cnt2), 32'(got.cnt2));
    endtask

    task automatic pattern(input logic clr_last, input string tag);
        step(1'b0, 1'b1, 1, 1'b0, tag);
        step(1'b0, 1'b1, 2, 1'b0, tag);
        step(1'b0, 1'b1, 3, 1'b0, tag);
        step(1'b0, 1'b1, 3, clr_last, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          seq[17];
        logic [16:0] ans_mask;
        logic [16:0] hit_mask;

        seq = '{0, 1, 1, 2, 3, 3, 1, 2, 1, 1, 1, 2, 2, 3, 3, 3, 1};

        // Reset held two cycles with num=1 presented.
        step(1'b1, 1'b1, 1, 1'b0, "rst");
        step(1'b1, 1'b1, 1, 1'b0, "rst");
        chk("rst_state", "stage", 32'(stage), 32'd0);

        // Overlapping patterns; ans/hit recorded per symbol (bit i = symbol i+1).
        ans_mask = '0;
        hit_mask = '0;
        foreach (seq[i]) begin
            step(1'b0, 1'b1, seq[i], 1'b0, "seq");
            ans_mask[i] = ans;
            hit_mask[i] = hit;
        end
        chk("seq_ans_pos", "mask", 32'(ans_mask), 32'h0_C020);
        chk("seq_hit_pos", "mask", 32'(hit_mask), 32'h0_4020);
        chk("seq_final",   "cnt",  32'(match_cnt), 32'd2);

        // Skipped stage aborts.
        step(1'b0, 1'b1, 1, 1'b0, "skip");
        step(1'b0, 1'b1, 3, 1'b0, "skip");
        chk("skip_abort", "stage", 32'(stage), 32'd0);
        step(1'b0, 1'b1, 3, 1'b0, "skip");

        // Backward step from the final stage aborts.
        step(1'b0, 1'b1, 1, 1'b0, "back");
        step(1'b0, 1'b1, 2, 1'b0, "back");
        step(1'b0, 1'b1, 3, 1'b0, "back");
        step(1'b0, 1'b1, 2, 1'b0, "back");

        // Enable gating: state holds at stage 1 while en=0.
        step(1'b0, 1'b1, 1, 1'b0, "en");
        step(1'b0, 1'b0, 2, 1'b0, "en_off");
        step(1'b0, 1'b0, 2, 1'b0, "en_off");
        chk("en_hold", "stage", 32'(stage), 32'd1);
        step(1'b0, 1'b1, 2, 1'b0, "en");
        step(1'b0, 1'b1, 3, 1'b0, "en");
        step(1'b0, 1'b1, 3, 1'b0, "en");
        chk("en_done", "hit", 32'(hit), 32'd1);
        // ans holds over a disabled cycle; extending the run does not re-pulse.
        step(1'b0, 1'b0, 0, 1'b0, "ans_hold");
        step(1'b0, 1'b1, 3, 1'b0, "extend");

        // Clear, then saturate the 2-bit counter and clear with a coincident hit.
        step(1'b0, 1'b1, 0, 1'b1, "clr");
        for (int k = 0; k < 5; k++) pattern(1'b0, "sat");
        chk("sat_cnt2", "cnt2", 32'(match_cnt2), 32'd3);
        chk("sat_cnt8", "cnt",  32'(match_cnt),  32'd5);
        pattern(1'b1, "clr_hit");
        chk("clr_hit2", "cnt2", 32'(match_cnt2), 32'd1);
        chk("clr_hit8", "cnt",  32'(match_cnt),  32'd1);

        // Reset mid-pattern discards progress one symbol short of a match.
        step(1'b0, 1'b1, 1, 1'b0, "midrst");
        step(1'b0, 1'b1, 2, 1'b0, "midrst");
        step(1'b0, 1'b1, 3, 1'b0, "midrst");
        step(1'b1, 1'b1, 0, 1'b0, "midrst_rst");
        chk("midrst_rst", "stage", 32'(stage), 32'd0);
        step(1'b0, 1'b1, 3, 1'b0, "midrst_after");
        chk("midrst_after", "stage", 32'(stage), 32'd0);
        chk("midrst_after", "hit",   32'(hit),   32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
